drive_signal_arbiter: RTL and testbench
=======================================

DRIVE_SIGNAL_ARBITER -- requirements
Module: drive_signal_arbiter

Interface
REQ-001 Parameter N_SRC, default 3; number of driving sources (manual, semi-auto, auto); legal range 2..8.
REQ-002 Parameter SIG_W, default 8; width of one source's signal bus.
REQ-003 Parameter HOLD_CYCLES, default 1000000 (10 ms at 100 MHz); safe-hold length on any source switch; minimum 1.
REQ-004 Parameter BRAKE_BIT, default 7; bit index of brake within a signal bus.
REQ-005 Derived constant MODE_W = max(1, clog2(N_SRC)).
REQ-006 clk  input  1  system clock, 100 MHz.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 power  input  1  car power-on level; 0 means off.
REQ-009 mode_req  input  MODE_W  requested source index.
REQ-010 src_sig  input  N_SRC*SIG_W  packed source buses; source k occupies bits [k*SIG_W +: SIG_W].
REQ-011 src_valid  input  N_SRC  per-source valid; 1 means the bus content is meaningful.
REQ-012 sig_out  output  SIG_W  arbitrated signal to the simulated device.
REQ-013 active_mode  output  MODE_W  index of the source currently granted.
REQ-014 switching  output  1  high while in HOLD.
REQ-015 fault  output  1  sticky error flag.

Function
REQ-016 The block SHALL be a three-state FSM: OFF, HOLD, ACTIVE.
REQ-017 All outputs SHALL be registered; sig_out reflects inputs sampled on the previous edge (1-cycle latency).
REQ-018 SAFE value SHALL be a bus with only BRAKE_BIT set (SIG_W=8: 0x80).
- OFF: sig_out=0, switching=0; on power=1 go to HOLD, target=mode_req, counter=0.
- HOLD: sig_out=SAFE, switching=1; counter increments each cycle.
- HOLD exit: at counter=HOLD_CYCLES-1, go to ACTIVE, active_mode=target.
- HOLD, mode_req≠target: restart counter at 0, target=mode_req.
- ACTIVE: sig_out=src_sig[active_mode] when src_valid[active_mode]=1, else SAFE.
- ACTIVE, mode_req≠active_mode: go to HOLD, target=mode_req.
REQ-019 power=0 in any state SHALL force OFF on the next edge; this overrides every other transition.
REQ-020 mode_req ≥ N_SRC SHALL set fault and keep the FSM in HOLD with the counter frozen at 0 until mode_req becomes legal.
REQ-021 src_valid[active_mode]=0 in ACTIVE for more than one consecutive cycle SHALL set fault.
REQ-022 fault SHALL clear only on reset or on the OFF->HOLD transition.
REQ-023 Only the granted source SHALL ever reach sig_out; no OR or sum of sources.
REQ-024 A mode_req change and a HOLD expiry on the same cycle SHALL restart the hold; ACTIVE is not entered.

Reset
REQ-025 While rst=0: state=OFF, sig_out=0, active_mode=0, target=0, counter=0, switching=0, fault=0.
REQ-026 Reset release SHALL take effect on the next clk edge; deassertion is synchronised through a 2-flop stage.

Structure
REQ-027 A shared package drive_pkg SHALL hold the state enumeration, SAFE-value function, BRAKE_BIT default and MODE_W function.
REQ-028 One sub-module, hold_timer (parametrised counter with start/restart/done), SHALL implement the hold count.

Verification (HOLD_CYCLES=4, N_SRC=3, SIG_W=8)
REQ-029 Scenario 1: power 0->1 with mode_req=1 and src1=0x05 valid. Required response: sig_out=0x80 for 4 cycles, then 0x05; active_mode=1.
REQ-030 Scenario 2: ACTIVE on source 1, mode_req->2 with src2=0x0A. Required response: 4 cycles of 0x80 with switching=1, then 0x0A.
REQ-031 Scenario 3: mode_req toggles 1->2 at hold cycle 2. Required response: hold restarts; exactly 4 further SAFE cycles before src2 is granted.
REQ-032 Scenario 4: mode_req=3. Required response: fault=1, sig_out=0x80 indefinitely; mode_req=0 resumes with a 4-cycle hold.
REQ-033 Scenario 5: ACTIVE, src_valid[active] low for 2 cycles. Required response: SAFE output, fault=1 sticky until power cycle.
REQ-034 Scenario 6: power=0 mid-HOLD, and rst=0 mid-ACTIVE. Required response: sig_out=0 next edge (power case), sig_out=0 immediately (reset case), all outputs at reset values.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared types and helpers for the drive signal arbiter.
// Holds the FSM state encoding, the safe-bus builder and the mode width rule.
package drive_pkg;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_HOLD   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam int BRAKE_BIT_DFLT = 7;
    localparam int MAX_SIG_W      = 64;

    function automatic int mode_w(input int n_src);
        return (n_src <= 2) ? 1 : $clog2(n_src);
    endfunction

    // Bus with only the brake bit asserted.
    function automatic logic [MAX_SIG_W-1:0] safe_word(input int brake_bit);
        logic [MAX_SIG_W-1:0] w;
        w = '0;
        w[brake_bit] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Safe-hold cycle counter: clr forces zero, en advances by one.
// Ports: clk, rst_n, clr, en, done (count reached HOLD_CYCLES-1).
module hold_timer #(
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/drive_signal_arbiter.sv
// Grants one of N_SRC driving sources to the device, with a safe hold on switch.
// Ports: clk, rst (async low), power, mode_req, src_sig/src_valid in; sig_out, active_mode, switching, fault out.
module drive_signal_arbiter
    import drive_pkg::*;
#(
    parameter  int N_SRC       = 3,
    parameter  int SIG_W       = 8,
    parameter  int HOLD_CYCLES = 1000000,
    parameter  int BRAKE_BIT   = BRAKE_BIT_DFLT,
    localparam int MODE_W      = mode_w(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   power,
    input  logic [MODE_W-1:0]      mode_req,
    input  logic [N_SRC*SIG_W-1:0] src_sig,
    input  logic [N_SRC-1:0]       src_valid,
    output logic [SIG_W-1:0]       sig_out,
    output logic [MODE_W-1:0]      active_mode,
    output logic                   switching,
    output logic                   fault
);

    localparam logic [MAX_SIG_W-1:0] SAFE_FULL = safe_word(BRAKE_BIT);
    localparam logic [SIG_W-1:0]     SAFE      = SAFE_FULL[SIG_W-1:0];
    localparam logic [MODE_W:0]      N_SRC_W   = (MODE_W+1)'(N_SRC);

    // Assert immediately, release only after two clean edges.
    logic [1:0] rst_sync;
    logic       rst_n_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_i = rst_sync[1];

    state_t            state;
    logic [MODE_W-1:0] target;
    logic              inv_seen;
    logic              legal;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_done;
    logic [SIG_W-1:0]  act_sig;
    logic [SIG_W-1:0]  tgt_sig;
    logic              act_valid;

    assign legal = ({1'b0, mode_req} < N_SRC_W);

    // Only the selected source is ever routed; invalid selects fall back to SAFE.
    always_comb begin
        act_sig   = SAFE;
        tgt_sig   = SAFE;
        act_valid = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (active_mode == MODE_W'(k)) begin
                act_valid = src_valid[k];
                if (src_valid[k]) act_sig = src_sig[k*SIG_W +: SIG_W];
            end
            if (target == MODE_W'(k) && src_valid[k]) begin
                tgt_sig = src_sig[k*SIG_W +: SIG_W];
            end
        end
    end

    // Counter runs only while holding on a stable, legal target.
    always_comb begin
        tmr_clr = !(state == S_HOLD && power && legal && mode_req == target);
        tmr_en  = !tmr_clr && !tmr_done;
    end

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst_n(rst_n_i),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .done (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_OFF;
            target      <= '0;
            active_mode <= '0;
            sig_out     <= '0;
            switching   <= 1'b0;
            fault       <= 1'b0;
            inv_seen    <= 1'b0;
        end else if (!power) begin
            state     <= S_OFF;
            sig_out   <= '0;
            switching <= 1'b0;
            inv_seen  <= 1'b0;
        end else begin
            unique case (state)
                S_OFF: begin
                    state     <= S_HOLD;
                    target    <= mode_req;
                    fault     <= 1'b0;
                    sig_out   <= SAFE;
                    switching <= 1'b1;
                end
                S_HOLD: begin
                    sig_out   <= SAFE;
                    switching <= 1'b1;
                    if (!legal) begin
                        fault  <= 1'b1;
                        target <= mode_req;
                    end else if (mode_req != target) begin
                        target <= mode_req;
                    end else if (tmr_done) begin
                        state       <= S_ACTIVE;
                        active_mode <= target;
                        sig_out     <= tgt_sig;
                        switching   <= 1'b0;
                        inv_seen    <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (!legal || mode_req != active_mode) begin
                        state     <= S_HOLD;
                        target    <= mode_req;
                        sig_out   <= SAFE;
                        switching <= 1'b1;
                        inv_seen  <= 1'b0;
                        if (!legal) fault <= 1'b1;
                    end else begin
                        sig_out   <= act_sig;
                        switching <= 1'b0;
                        // Second consecutive invalid cycle is a fault.
                        if (!act_valid) begin
                            if (inv_seen) fault <= 1'b1;
                            inv_seen <= 1'b1;
                        end else begin
                            inv_seen <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_OFF;
                    sig_out   <= '0;
                    switching <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drive_signal_arbiter.sv
// Directed bench for drive_signal_arbiter with a 4-cycle hold.
// Ports driven: clk, rst, power, mode_req, src_sig, src_valid.
module tb_drive_signal_arbiter;

    logic        clk;
    logic        rst;
    logic        power;
    logic [1:0]  mode_req;
    logic [23:0] src_sig;
    logic [2:0]  src_valid;
    logic [7:0]  sig_out;
    logic [1:0]  active_mode;
    logic        switching;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    drive_signal_arbiter #(
        .N_SRC      (3),
        .SIG_W      (8),
        .HOLD_CYCLES(4),
        .BRAKE_BIT  (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .power      (power),
        .mode_req   (mode_req),
        .src_sig    (src_sig),
        .src_valid  (src_valid),
        .sig_out    (sig_out),
        .active_mode(active_mode),
        .switching  (switching),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] s,
                              input logic sw, input logic f);
        check({tag, ".sig"}, 32'(sig_out), 32'(s));
        check({tag, ".sw"}, 32'(switching), 32'(sw));
        check({tag, ".fault"}, 32'(fault), 32'(f));
    endtask

    task automatic hold4(input string tag, input logic f);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out(tag, 8'h80, 1'b1, f);
        end
    endtask

    initial begin
        rst       = 1'b0;
        power     = 1'b0;
        mode_req  = 2'd0;
        src_sig   = {8'h0A, 8'h05, 8'h33};
        src_valid = 3'b111;
        tick();
        tick();
        expect_out("reset", 8'h00, 1'b0, 1'b0);
        check("reset.mode", 32'(active_mode), 32'd0);

        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        expect_out("off", 8'h00, 1'b0, 1'b0);

        // Power up onto source 1
        mode_req = 2'd1;
        power    = 1'b1;
        hold4("s1.hold", 1'b0);
        tick();
        expect_out("s1.act", 8'h05, 1'b0, 1'b0);
        check("s1.mode", 32'(active_mode), 32'd1);

        // Switch to source 2
        mode_req = 2'd2;
        hold4("s2.hold", 1'b0);
        tick();
        expect_out("s2.act", 8'h0A, 1'b0, 1'b0);
        check("s2.mode", 32'(active_mode), 32'd2);

        // Request changes mid-hold: hold restarts
        mode_req = 2'd1;
        tick();
        tick();
        mode_req = 2'd2;
        hold4("s3.hold", 1'b0);
        tick();
        expect_out("s3.act", 8'h0A, 1'b0, 1'b0);
        check("s3.mode", 32'(active_mode), 32'd2);

        // Illegal request
        mode_req = 2'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_out("s4.bad", 8'h80, 1'b1, 1'b1);
        end
        mode_req = 2'd0;
        hold4("s4.hold", 1'b1);
        tick();
        expect_out("s4.act", 8'h33, 1'b0, 1'b1);
        check("s4.mode", 32'(active_mode), 32'd0);

        // Power cycle clears fault
        power = 1'b0;
        tick();
        expect_out("pc.off", 8'h00, 1'b0, 1'b1);
        power = 1'b1;
        hold4("pc.hold", 1'b0);
        tick();
        expect_out("pc.act", 8'h33, 1'b0, 1'b0);

        // Single invalid cycle: safe but no fault
        src_valid = 3'b110;
        tick();
        expect_out("s5.inv1", 8'h80, 1'b0, 1'b0);
        src_valid = 3'b111;
        tick();
        expect_out("s5.ok", 8'h33, 1'b0, 1'b0);

        // Two invalid cycles: fault, sticky
        src_valid = 3'b110;
        tick();
        expect_out("s5.inv2a", 8'h80, 1'b0, 1'b0);
        tick();
        expect_out("s5.inv2b", 8'h80, 1'b0, 1'b1);
        src_valid = 3'b111;
        tick();
        expect_out("s5.sticky", 8'h33, 1'b0, 1'b1);

        // Power off mid-hold
        mode_req = 2'd1;
        tick();
        tick();
        power = 1'b0;
        tick();
        expect_out("s6.off", 8'h00, 1'b0, 1'b1);

        // Request change coincident with hold expiry
        power = 1'b1;
        hold4("s6.hold", 1'b0);
        mode_req = 2'd2;
        hold4("s6.rehold", 1'b0);
        tick();
        expect_out("s6.act", 8'h0A, 1'b0, 1'b0);
        check("s6.mode", 32'(active_mode), 32'd2);

        // Reset mid-active takes effect immediately
        #2;
        rst = 1'b0;
        #1;
        expect_out("s6.rst", 8'h00, 1'b0, 1'b0);
        check("s6.rstmode", 32'(active_mode), 32'd0);
        tick();
        expect_out("s6.rsthold", 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
